// File: rtl/rand_pkg.sv
// Shared constants and the round-robin pick helper for the random-source arbiter.
// The LFSR polynomial x^9+x^5+1 is maximal, so the sequence has period 511.
package rand_pkg;

   localparam int              LFSR_W      = 9;
   localparam int              LFSR_TAP_HI = 8;
   localparam int              LFSR_TAP_LO = 4;
   localparam logic [8:0]      LFSR_RESET  = 9'h1FF;
   localparam int              MAX_REQ     = 8;

   // First set bit of eligible at or above ptr, wrapping modulo num_req.
   function automatic logic [2:0] rr_pick(input logic [7:0] eligible,
                                          input logic [2:0] ptr,
                                          input int         num_req);
      logic [2:0] pick;
      int         idx;
      pick = 3'd0;
      // Walk offsets from the far end so the closest eligible index wins last.
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < num_req) begin
            idx = (int'(ptr) + k) % num_req;
            if (eligible[idx]) begin
               pick = idx[2:0];
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rand_arbiter_lfsr9.sv
// Free-running 9-bit Fibonacci LFSR with synchronous reload.
// A zero load value would lock the register, so it is replaced by the reset pattern.
module lfsr9
   import rand_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] r_state;
   logic [LFSR_W-1:0] w_next;
   logic              w_fb;

   // Next-state: reload (with zero substitution) or shift in feedback.
   always_comb begin
      w_fb   = r_state[LFSR_TAP_HI] ^ r_state[LFSR_TAP_LO];
      w_next = {r_state[LFSR_W-2:0], w_fb};
      if (load) begin
         if (load_val == 9'd0) begin
            w_next = LFSR_RESET;
         end else begin
            w_next = load_val;
         end
      end else begin
         w_next = {r_state[LFSR_W-2:0], w_fb};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= LFSR_RESET;
      end else begin
         r_state <= w_next;
      end
   end

   assign state = r_state;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ req/ack requesters.
// Each req assertion earns exactly one word; seed loading pre-empts granting.
module rand_arbiter
   import rand_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   output logic [WIDTH-1:0]   rnd_data,
   input  logic               seed_load,
   input  logic [LFSR_W-1:0]  seed,
   output logic               busy
);

   logic [LFSR_W-1:0]  w_lfsr;
   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_served_nxt;
   logic [7:0]         w_elig_ext;
   logic [2:0]         w_pick;
   logic [2:0]         w_ptr_nxt;
   logic               w_do_grant;
   logic               w_unused_lfsr;

   logic [NUM_REQ-1:0] r_served;
   logic [NUM_REQ-1:0] r_ack;
   logic [WIDTH-1:0]   r_rnd;
   logic [2:0]         r_rr_ptr;

   lfsr9 u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .load     (seed_load),
      .load_val (seed),
      .state    (w_lfsr)
   );

   assign w_eligible    = req & ~r_served;
   assign busy          = |w_eligible;
   assign w_unused_lfsr = ^w_lfsr;

   // Grant selection; a seed load suppresses any grant this cycle.
   always_comb begin
      w_elig_ext                = 8'd0;
      w_elig_ext[NUM_REQ-1:0]   = w_eligible;
      w_pick                    = rr_pick(w_elig_ext, r_rr_ptr, NUM_REQ);
      w_do_grant                = (|w_eligible) && !seed_load;
      w_grant                   = '0;
      w_ptr_nxt                 = r_rr_ptr;
      if (w_do_grant) begin
         w_grant   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
         w_ptr_nxt = (w_pick == 3'(NUM_REQ - 1)) ? 3'd0 : w_pick + 3'd1;
      end else begin
         w_grant   = '0;
         w_ptr_nxt = r_rr_ptr;
      end
      // Dropping req re-arms the requester even on the cycle it is acked.
      w_served_nxt = (r_served | w_grant) & req;
   end

   // Served mask, pointer and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_served <= '0;
         r_ack    <= '0;
         r_rnd    <= '0;
         r_rr_ptr <= 3'd0;
      end else begin
         r_served <= w_served_nxt;
         r_ack    <= w_grant;
         if (w_do_grant) begin
            r_rnd    <= w_lfsr[WIDTH-1:0];
            r_rr_ptr <= w_ptr_nxt;
         end else begin
            r_rnd    <= r_rnd;
            r_rr_ptr <= r_rr_ptr;
         end
      end
   end

   assign ack      = r_ack;
   assign rnd_data = r_rnd;

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_rand_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] ack;
   logic [W-1:0] rnd_data;
   logic         seed_load = 1'b0;
   logic [8:0]   seed = 9'd0;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [8:0]   m_lfsr;
   logic [N-1:0] m_served;
   logic [N-1:0] m_ack;
   logic [W-1:0] m_rnd;
   int           m_ptr;

   rand_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .ack       (ack),
      .rnd_data  (rnd_data),
      .seed_load (seed_load),
      .seed      (seed),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Polynomial x^9+x^5+1 as shift-and-add arithmetic.
   function automatic logic [8:0] lfsr_next(input logic [8:0] s);
      int v;
      v = int'(s);
      return 9'(((v * 2) % 512) | (((v >> 8) ^ (v >> 4)) & 1));
   endfunction

   task automatic model_reset();
      m_lfsr   = 9'h1FF;
      m_served = '0;
      m_ack    = '0;
      m_rnd    = '0;
      m_ptr    = 0;
   endtask

   task automatic model_edge();
      logic [N-1:0] elig;
      logic [8:0]   nxt;
      int           pick;
      elig = req & ~m_served;
      pick = -1;
      if (seed_load) nxt = (seed == 9'd0) ? 9'h1FF : seed;
      else           nxt = lfsr_next(m_lfsr);
      m_ack = '0;
      if (!seed_load && elig != '0) begin
         for (int k = 0; k < N; k++)
            if (pick < 0 && elig[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
         m_ack[pick] = 1'b1;
         m_rnd       = m_lfsr[W-1:0];
         m_ptr       = (pick + 1) % N;
      end
      for (int j = 0; j < N; j++) begin
         if (!req[j])       m_served[j] = 1'b0;
         else if (pick == j) m_served[j] = 1'b1;
      end
      m_lfsr = nxt;
   endtask

   // One clock: inputs set at negedge, outputs checked just after posedge.
   task automatic step();
      #1;
      check_val("busy", 32'(busy), 32'((req & ~m_served) != '0));
      model_edge();
      @(posedge clk);
      #1;
      check_val("ack", 32'(ack), 32'(m_ack));
      check_val("rnd_data", 32'(rnd_data), 32'(m_rnd));
      check_val("lfsr", 32'(dut.w_lfsr), 32'(m_lfsr));
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_val("rst_ack", 32'(ack), 32'd0);
      check_val("rst_rnd", 32'(rnd_data), 32'd0);
      check_val("rst_served", 32'(dut.r_served), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [8:0] seq [6];
      logic [7:0] rr_rnd [4];
      int         first_ret;
      seq    = '{9'h1FE, 9'h1FC, 9'h1F8, 9'h1F0, 9'h1E0, 9'h1C1};
      rr_rnd = '{8'hFF, 8'hFE, 8'hFC, 8'hF8};

      @(negedge clk);
      do_reset();
      check_val("rst_lfsr", 32'(dut.w_lfsr), 32'h1FF);

      for (int i = 0; i < 6; i++) begin
         step();
         check_val("lfsr_seq", 32'(dut.w_lfsr), 32'(seq[i]));
      end
      first_ret = 0;
      for (int e = 7; e <= 511; e++) begin
         step();
         if (first_ret == 0 && dut.w_lfsr == 9'h1FF) first_ret = e;
      end
      check_val("lfsr_period", 32'(first_ret), 32'd511);

      req = 4'b0001;
      step();
      check_val("single_ack", 32'(ack), 32'h1);
      check_val("single_rnd", 32'(rnd_data), 32'hFF);
      step();
      step();
      check_val("single_hold", 32'(ack), 32'h0);
      req = 4'b0000;
      step();
      req = 4'b0001;
      step();
      check_val("single_rearm", 32'(ack), 32'h1);

      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("rr_ack", 32'(ack), 32'(1 << i));
         check_val("rr_rnd", 32'(rnd_data), 32'(rr_rnd[i]));
         req = req & ~ack;
      end

      do_reset();
      req = 4'b0010;
      step();
      req = 4'b0000;
      step();
      req = 4'b0011;
      step();
      check_val("fair_first", 32'(ack), 32'h1);
      step();
      check_val("fair_second", 32'(ack), 32'h2);

      req = 4'b0000;
      step();
      req       = 4'b0001;
      seed_load = 1'b1;
      seed      = 9'h0A5;
      step();
      check_val("seed_noack", 32'(ack), 32'h0);
      check_val("seed_lfsr", 32'(dut.w_lfsr), 32'h0A5);
      seed_load = 1'b0;
      step();
      check_val("seed_ack", 32'(ack), 32'h1);
      check_val("seed_rnd", 32'(rnd_data), 32'hA5);
      req       = 4'b0000;
      seed_load = 1'b1;
      seed      = 9'h000;
      step();
      check_val("seed_zero", 32'(dut.w_lfsr), 32'h1FF);
      seed_load = 1'b0;

      do_reset();
      req = 4'b0100;
      step();
      check_val("mid_ack", 32'(ack), 32'h4);
      #2;
      do_reset();
      step();
      check_val("post_rst_ack", 32'(ack), 32'h4);
      check_val("post_rst_rnd", 32'(rnd_data), 32'hFF);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
         seed_load = ($urandom_range(0, 15) == 0);
         seed      = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
         if ($urandom_range(0, 400) == 0) begin
            seed_load = 1'b0;
            do_reset();
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
